// File: rtl/issue_queue_ctrl.sv
// Issue-queue controller: in-order dispatch allocation, oldest-first issue
// across several execution units, pairwise age matrix, flush and occupancy.
module issue_queue_ctrl #(
    parameter  int DEPTH = 4,
    parameter  int NLOAD = 2,
    parameter  int NEXE  = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NLOAD-1:0]         iqLoads,
    input  logic [NEXE-1:0]          exeReady,
    input  logic [DEPTH-1:0]         opsReady,
    input  logic [DEPTH-1:0]         flush,
    input  logic                     flushAll,
    output logic [DEPTH*NLOAD-1:0]   load,
    output logic [NLOAD-1:0]         loadAck,
    output logic [NEXE*DEPTH-1:0]    issue,
    output logic [DEPTH-1:0]         valid,
    output logic [CW-1:0]            count
);

    localparam int PW = (NLOAD > 1) ? $clog2(NLOAD) : 1;

    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0]       r_older [DEPTH];
    logic [CW-1:0]          r_count;

    logic [DEPTH*NLOAD-1:0] w_load;
    logic [NLOAD-1:0]       w_ack;
    logic [DEPTH-1:0]       w_taken;
    logic [PW-1:0]          w_ldport [DEPTH];
    logic [DEPTH-1:0]       w_cand;
    logic [CW-1:0]          w_crank [DEPTH];
    logic [CW-1:0]          w_urank [NEXE];
    logic [NEXE*DEPTH-1:0]  w_issue;
    logic [DEPTH-1:0]       w_issued;
    logic [DEPTH-1:0]       w_nv;
    logic [DEPTH-1:0]       w_older_nx [DEPTH];
    logic [CW-1:0]          w_count_nx;

    // Each requesting port, in port order, claims the lowest free entry left.
    always_comb begin
        w_load  = '0;
        w_ack   = '0;
        w_taken = '0;
        for (int p = 0; p < NLOAD; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iqLoads[p] && !w_ack[p] && !r_valid[i] && !w_taken[i]) begin
                    w_load[i*NLOAD+p] = 1'b1;
                    w_ack[p]          = 1'b1;
                    w_taken[i]        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ldport[i] = '0;
            for (int p = 0; p < NLOAD; p++) begin
                if (w_load[i*NLOAD+p]) begin
                    w_ldport[i] = PW'(p);
                end
            end
        end
    end

    // Candidate rank = number of older candidates; unit rank = ready units below.
    always_comb begin
        w_cand = r_valid & opsReady;
        for (int i = 0; i < DEPTH; i++) begin
            w_crank[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && w_cand[j] && r_older[j][i]) begin
                    w_crank[i] = w_crank[i] + CW'(1);
                end
            end
        end
        for (int k = 0; k < NEXE; k++) begin
            w_urank[k] = '0;
            for (int kk = 0; kk < k; kk++) begin
                if (exeReady[kk]) begin
                    w_urank[k] = w_urank[k] + CW'(1);
                end
            end
        end
        w_issue  = '0;
        w_issued = '0;
        for (int k = 0; k < NEXE; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (exeReady[k] && w_cand[i] && w_urank[k] == w_crank[i]) begin
                    w_issue[k*DEPTH+i] = 1'b1;
                    w_issued[i]        = 1'b1;
                end
            end
        end
    end

    assign w_nv = ~flush & {DEPTH{~flushAll}}
                & ((r_valid & ~w_issued) | w_taken);

    always_comb begin
        w_count_nx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_nx = w_count_nx + CW'(w_nv[i]);
        end
    end

    // Survivors keep their order and are older than anything loaded now.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_older_nx[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (i != j && w_nv[i] && w_nv[j]) begin
                    if (!w_taken[i] && !w_taken[j]) begin
                        w_older_nx[i][j] = r_older[i][j];
                    end else if (!w_taken[i]) begin
                        w_older_nx[i][j] = 1'b1;
                    end else if (!w_taken[j]) begin
                        w_older_nx[i][j] = 1'b0;
                    end else begin
                        w_older_nx[i][j] = w_ldport[i] < w_ldport[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            r_valid <= w_nv;
            r_count <= w_count_nx;
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= w_older_nx[i];
            end
        end
    end

    assign load    = w_load;
    assign loadAck = w_ack;
    assign issue   = w_issue;
    assign valid   = r_valid;
    assign count   = r_count;

    // Age matrix must stay a strict total order over the valid entries.
    always @(posedge clock) begin
        if (!reset) begin
            assert (32'(r_count) == $countones(r_valid));
            for (int i = 0; i < DEPTH; i++) begin
                assert (!r_older[i][i]);
                for (int j = 0; j < DEPTH; j++) begin
                    if (i != j) begin
                        assert (!r_older[i][j] || (r_valid[i] && r_valid[j]));
                        if (r_valid[i] && r_valid[j]) begin
                            assert (r_older[i][j] ^ r_older[j][i]);
                        end
                        for (int k = 0; k < DEPTH; k++) begin
                            if (k != i && k != j) begin
                                assert (!(r_older[i][j] && r_older[j][k])
                                        || r_older[i][k]);
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Bench for issue_queue_ctrl: directed scenarios on the default build and
// randomized traffic on an 8-entry build, both against an age-list model.
module tb_issue_queue_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: per instance, entries listed oldest first.
    int m_age [2][16];
    int m_n   [2];

    logic [63:0] s_load, s_iss;
    logic [63:0] s_ack;

    logic [1:0]  a_ld, a_exr, a_ack;
    logic [3:0]  a_ops, a_fl, a_valid;
    logic        a_fla;
    logic [7:0]  a_load, a_iss;
    logic [2:0]  a_count;

    logic [2:0]  b_ld, b_ack;
    logic [1:0]  b_exr;
    logic [7:0]  b_ops, b_fl, b_valid;
    logic        b_fla;
    logic [23:0] b_load;
    logic [15:0] b_iss;
    logic [3:0]  b_count;

    issue_queue_ctrl u_dut_a (
        .clock(clk), .reset(rst),
        .iqLoads(a_ld), .exeReady(a_exr), .opsReady(a_ops),
        .flush(a_fl), .flushAll(a_fla),
        .load(a_load), .loadAck(a_ack), .issue(a_iss),
        .valid(a_valid), .count(a_count)
    );

    issue_queue_ctrl #(.DEPTH(8), .NLOAD(3), .NEXE(2)) u_dut_b (
        .clock(clk), .reset(rst),
        .iqLoads(b_ld), .exeReady(b_exr), .opsReady(b_ops),
        .flush(b_fl), .flushAll(b_fla),
        .load(b_load), .loadAck(b_ack), .issue(b_iss),
        .valid(b_valid), .count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mvalid(input int m);
        logic [15:0] v;
        v = '0;
        for (int x = 0; x < m_n[m]; x++) v[m_age[m][x]] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input int m, input int d, input int nl,
                              input int ne, input logic [15:0] ld,
                              input logic [15:0] exr, input logic [15:0] ops,
                              input logic [15:0] fl, input logic fla,
                              output logic [63:0] e_load,
                              output logic [63:0] e_ack,
                              output logic [63:0] e_iss);
        logic [15:0] v;
        int fr[$];
        int un[$];
        int ca[$];
        int na[$];
        int ldent[16];
        bit issued[16];
        int r;
        v = mvalid(m);
        e_load = '0;
        e_ack = '0;
        e_iss = '0;
        for (int i = 0; i < 16; i++) begin
            ldent[i] = -1;
            issued[i] = 1'b0;
        end
        for (int i = 0; i < d; i++) if (!v[i]) fr.push_back(i);
        r = 0;
        for (int p = 0; p < nl; p++) begin
            if (ld[p]) begin
                if (r < fr.size()) begin
                    e_load[fr[r]*nl+p] = 1'b1;
                    e_ack[p] = 1'b1;
                    ldent[p] = fr[r];
                end
                r++;
            end
        end
        for (int k = 0; k < ne; k++) if (exr[k]) un.push_back(k);
        for (int x = 0; x < m_n[m]; x++)
            if (ops[m_age[m][x]]) ca.push_back(m_age[m][x]);
        for (int x = 0; x < un.size() && x < ca.size(); x++) begin
            e_iss[un[x]*d+ca[x]] = 1'b1;
            issued[ca[x]] = 1'b1;
        end
        if (!fla) begin
            for (int x = 0; x < m_n[m]; x++) begin
                if (!issued[m_age[m][x]] && !fl[m_age[m][x]])
                    na.push_back(m_age[m][x]);
            end
            for (int p = 0; p < nl; p++)
                if (ldent[p] >= 0 && !fl[ldent[p]]) na.push_back(ldent[p]);
        end
        m_n[m] = na.size();
        for (int x = 0; x < na.size(); x++) m_age[m][x] = na[x];
    endtask

    task automatic cyc_a(input logic [1:0] ld, input logic [1:0] exr,
                         input logic [3:0] ops, input logic [3:0] fl,
                         input logic fla);
        logic [63:0] el, ea, ei;
        a_ld = ld; a_exr = exr; a_ops = ops; a_fl = fl; a_fla = fla;
        #2;
        chk("a_valid", 64'(a_valid), 64'(mvalid(0)));
        chk("a_count", 64'(a_count), 64'(m_n[0]));
        model_step(0, 4, 2, 2, 16'(ld), 16'(exr), 16'(ops), 16'(fl), fla,
                   el, ea, ei);
        s_load = 64'(a_load); s_ack = 64'(a_ack); s_iss = 64'(a_iss);
        chk("a_load", s_load, el);
        chk("a_ack", s_ack, ea);
        chk("a_issue", s_iss, ei);
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input logic [2:0] ld, input logic [1:0] exr,
                         input logic [7:0] ops, input logic [7:0] fl,
                         input logic fla);
        logic [63:0] el, ea, ei;
        b_ld = ld; b_exr = exr; b_ops = ops; b_fl = fl; b_fla = fla;
        #2;
        chk("b_valid", 64'(b_valid), 64'(mvalid(1)));
        chk("b_count", 64'(b_count), 64'(m_n[1]));
        model_step(1, 8, 3, 2, 16'(ld), 16'(exr), 16'(ops), 16'(fl), fla,
                   el, ea, ei);
        chk("b_load", 64'(b_load), el);
        chk("b_ack", 64'(b_ack), ea);
        chk("b_issue", 64'(b_iss), ei);
        @(posedge clk); #1;
    endtask

    initial begin
        m_n[0] = 0;
        m_n[1] = 0;
        rst = 1'b1;
        a_ld = '0; a_exr = '1; a_ops = '1; a_fl = '0; a_fla = 1'b0;
        b_ld = '0; b_exr = '0; b_ops = '0; b_fl = '0; b_fla = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", 64'(a_valid), 64'h0);
        chk("rst_count", 64'(a_count), 64'h0);
        chk("rst_issue", 64'(a_iss), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        cyc_a(2'b11, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("tp_load01", s_load, 64'h09);
        chk("tp_ack11", s_ack, 64'h3);
        chk("tp_valid0011", 64'(a_valid), 64'h3);
        chk("tp_count2", 64'(a_count), 64'h2);
        cyc_a(2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc_a(2'b11, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("tp_partial_ack", s_ack, 64'h1);
        chk("tp_partial_load", s_load, 64'h40);
        chk("tp_count4", 64'(a_count), 64'h4);
        cyc_a(2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("tp_full_ack", s_ack, 64'h0);
        chk("tp_full_load", s_load, 64'h0);
        cyc_a(2'b00, 2'b10, 4'b0100, 4'h0, 1'b0);
        chk("tp_unit1_only", s_iss, 64'h40);
        cyc_a(2'b00, 2'b11, 4'hf, 4'h0, 1'b0);
        chk("tp_two_oldest", s_iss, 64'h21);
        cyc_a(2'b11, 2'b01, 4'b1000, 4'b0010, 1'b0);
        chk("tp_flush_ack", s_ack, 64'h3);
        chk("tp_flush_valid", 64'(a_valid), 64'h1);
        cyc_a(2'b11, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("tp_flushall_ack", s_ack, 64'h3);
        chk("tp_flushall_valid", 64'(a_valid), 64'h0);
        chk("tp_flushall_count", 64'(a_count), 64'h0);

        cyc_a(2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc_a(2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc_a(2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc_a(2'b00, 2'b11, 4'b0101, 4'h0, 1'b0);
        chk("tp_age_pair", s_iss, 64'h41);
        cyc_a(2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc_a(2'b00, 2'b01, 4'b0011, 4'h0, 1'b0);
        chk("tp_age_not_index", s_iss, 64'h02);
        cyc_a(2'b11, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc_a(2'b11, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("tp_full_count", 64'(a_count), 64'h4);

        a_ld = '0; a_exr = '1; a_ops = '1; a_fl = '0; a_fla = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(a_valid), 64'h0);
        chk("mid_rst_count", 64'(a_count), 64'h0);
        chk("mid_rst_issue", 64'(a_iss), 64'h0);
        m_n[0] = 0;
        m_n[1] = 0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        for (int c = 0; c < 300; c++) begin
            cyc_a(2'($urandom), 2'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0,
                  $urandom_range(0, 63) == 0);
        end
        a_ld = '0; a_exr = '0; a_ops = '0; a_fl = '0; a_fla = 1'b0;

        for (int c = 0; c < 2000; c++) begin
            cyc_b(3'($urandom), 2'($urandom), 8'($urandom),
                  ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0,
                  $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
